// File: rtl/spi_frame_rx_pkg.sv
// Shared definitions for the SPI counter-readout link: receiver FSM encoding
// and the default frame width both ends of the link agree on.
package spi_frame_rx_pkg;

  localparam int FRAME_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a registered
// copy of the synchronised level so rising and falling edges can be decoded.
module sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: the chain resets to the line's idle level so that leaving reset never
  // fabricates an edge out of a quiet line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {STAGES{RESET_LEVEL}};
      r_prev <= RESET_LEVEL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  =  r_sync[STAGES-1] & ~r_prev;
  assign fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI frame receiver: rebuilds BITS-wide MSB-first words from
// SS/SCLK/MOSI and hands them to a local consumer over valid/ready.
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int BITS        = FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ss_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic [BITS-1:0]  data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int              BC_W    = $clog2(BITS + 2);
  localparam logic [BC_W-1:0] BC_GOOD = BC_W'(BITS);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(BITS + 1);
  localparam int              AR_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [AR_W-1:0] AR_FULL = AR_W'(SYNC_STAGES);

  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall_unused;
  logic w_mosi_level, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_start;

  rx_state_t         r_state;
  logic [BITS-1:0]   r_shreg;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_pend;
  logic              r_mosi_d;
  logic [AR_W-1:0]   r_arm_cnt;
  logic              r_armed;
  logic [BITS-1:0]   r_data_out;
  logic              r_data_valid;
  logic              r_frame_err;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_good_count;
  logic [CNT_W-1:0]  r_err_count;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ss_n),
    .level   (w_ss_level),
    .rise    (w_ss_rise),
    .fall    (w_ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sclk),
    .level   (w_sclk_level_unused),
    .rise    (w_sclk_rise),
    .fall    (w_sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (mosi),
    .level   (w_mosi_level),
    .rise    (w_mosi_rise_unused),
    .fall    (w_mosi_fall_unused)
  );

  // A frame may only start once ss_n has been seen high with real samples in
  // the synchroniser; a reset released mid-frame must skip the rest of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mosi_d  <= 1'b0;
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_mosi_d <= w_mosi_level;
      if (r_arm_cnt != AR_FULL) r_arm_cnt <= r_arm_cnt + AR_W'(1);
      if (r_arm_cnt == AR_FULL && w_ss_level) r_armed <= 1'b1;
    end
  end

  assign w_start = w_ss_fall & r_armed;

  // NOTE: every register here is updated with <= so all decisions in a cycle
  // see the same pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_pend       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_good_count <= '0;
      r_err_count  <= '0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_data_valid && data_ready) r_data_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start || r_pend) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_pend    <= 1'b0;
            r_state   <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (w_ss_rise) begin
            r_state <= ST_CHECK;
          end else if (w_sclk_rise) begin
            r_shreg <= {r_shreg[BITS-2:0], r_mosi_d};
            if (r_bit_cnt != BC_SAT) r_bit_cnt <= r_bit_cnt + BC_W'(1);
          end
        end

        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (w_start) r_pend <= 1'b1;
          if (r_bit_cnt == BC_GOOD) begin
            // The slot is free if empty or being emptied on this very edge.
            if (!r_data_valid || data_ready) begin
              r_data_out   <= r_shreg;
              r_data_valid <= 1'b1;
              r_good_count <= r_good_count + CNT_W'(1);
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_frame_err <= 1'b1;
            r_err_count <= r_err_count + CNT_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign good_count = r_good_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a frame-level model predicts every output on
// every clock, plus literal expectations after each scenario.
module tb_spi_frame_rx;
  import spi_frame_rx_pkg::*;

  localparam int BITS  = 32;
  localparam int SYNC  = 2;
  localparam int CNT_W = 16;
  localparam int HALF  = 4;          // sclk half period in clk cycles (sclk = clk/8)
  localparam int LAT   = SYNC + 2;   // posedges from a negedge-driven ss_n rise to the result

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ss_n = 1'b1;
  logic             sclk = 1'b0;
  logic             mosi = 1'b0;
  logic             data_ready = 1'b0;
  logic [BITS-1:0]  data_out;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;
  logic [CNT_W-1:0] good_count;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  spi_frame_rx #(.BITS(BITS), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ss_n       (ss_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .good_count (good_count),
    .err_count  (err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each finished frame becomes one event at the cycle its
  // verdict must be visible; the handshake is tracked from data_ready alone.
  typedef struct {
    int          due;
    bit          good;
    logic [31:0] word;
  } ev_t;

  ev_t              evq[$];
  int               cyc = 0;
  logic [31:0]      m_data = '0;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;
  bit               m_ovr = 1'b0;
  logic [CNT_W-1:0] m_good = '0;
  logic [CNT_W-1:0] m_errc = '0;

  int          n_err_pulse = 0;
  int          n_ovr_pulse = 0;
  int          n_valid_rise = 0;
  bit          prev_valid = 1'b0;
  logic [31:0] seen[$];

  always begin
    ev_t ev;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      m_good = '0; m_errc = '0;
      evq.delete();
    end else begin
      m_err = 1'b0;
      m_ovr = 1'b0;
      if (m_valid && data_ready) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (!ev.good) begin
          m_err  = 1'b1;
          m_errc = m_errc + CNT_W'(1);
        end else if (!m_valid) begin
          m_data  = ev.word;
          m_valid = 1'b1;
          m_good  = m_good + CNT_W'(1);
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    #1;
    check("data_out",   64'(data_out),   64'(m_data));
    check("data_valid", 64'(data_valid), 64'(m_valid));
    check("frame_err",  64'(frame_err),  64'(m_err));
    check("overrun",    64'(overrun),    64'(m_ovr));
    check("good_count", 64'(good_count), 64'(m_good));
    check("err_count",  64'(err_count),  64'(m_errc));
    if (frame_err) n_err_pulse++;
    if (overrun) n_ovr_pulse++;
    if (data_valid && !prev_valid) n_valid_rise++;
    prev_valid = data_valid;
    if (data_valid && data_ready) seen.push_back(data_out);
  end

  task automatic send_bits(input logic [63:0] word, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi = word[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] word, input int nbits, input int gap_clks);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(word, nbits - 1, 0);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    evq.push_back('{due: cyc + LAT, good: (nbits == BITS), word: word[31:0]});
    repeat (gap_clks) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, o0, v0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst data_out",   64'(data_out),   64'h0);
    check("rst data_valid", 64'(data_valid), 64'h0);
    check("rst good_count", 64'(good_count), 64'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single good frame, consumer always ready
    data_ready = 1'b1;
    e0 = n_err_pulse; v0 = n_valid_rise;
    send_frame(64'h0000_3039, 32, 20);
    check("t1 good_count",  64'(good_count),         64'd1);
    check("t1 data_out",    64'(data_out),           64'h3039);
    check("t1 valid pulses", 64'(n_valid_rise - v0), 64'd1);
    check("t1 no frame_err", 64'(n_err_pulse - e0),  64'd0);

    // Short then long frame
    do_reset();
    e0 = n_err_pulse;
    send_frame(64'h7FFF_FFFF, 31, 20);
    send_frame(64'h1_8000_0001, 33, 20);
    check("t2 err_count",   64'(err_count),         64'd2);
    check("t2 err pulses",  64'(n_err_pulse - e0),  64'd2);
    check("t2 data_out",    64'(data_out),          64'h0);
    check("t2 data_valid",  64'(data_valid),        64'h0);

    // Consumer stalled: second word dropped
    do_reset();
    data_ready = 1'b0;
    o0 = n_ovr_pulse;
    send_frame(64'hDEAD_BEEF, 32, 20);
    send_frame(64'h1234_5678, 32, 20);
    check("t3 data_out",    64'(data_out),          64'hDEAD_BEEF);
    check("t3 data_valid",  64'(data_valid),        64'h1);
    check("t3 good_count",  64'(good_count),        64'd1);
    check("t3 overruns",    64'(n_ovr_pulse - o0),  64'd1);
    @(negedge clk);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3 valid drop",  64'(data_valid),        64'h0);

    // Back-to-back frames with a two-sclk-period gap
    do_reset();
    seen.delete();
    send_frame(64'hAAAA_AAAA, 32, 2 * 2 * HALF);
    send_frame(64'h5555_5555, 32, 20);
    check("t4 words seen",  64'(seen.size()),       64'd2);
    if (seen.size() == 2) begin
      check("t4 word0",     64'(seen[0]),           64'hAAAA_AAAA);
      check("t4 word1",     64'(seen[1]),           64'h5555_5555);
    end
    check("t4 good_count",  64'(good_count),        64'd2);

    // Reset mid-frame; the rest of that frame must be ignored
    e0 = n_err_pulse;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(64'hFFFF_0000, 31, 16);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 rst data_out",   64'(data_out),   64'h0);
    check("t5 rst data_valid", 64'(data_valid), 64'h0);
    check("t5 rst good_count", 64'(good_count), 64'h0);
    check("t5 rst err_count",  64'(err_count),  64'h0);
    reset_n = 1'b1;
    send_bits(64'hFFFF_0000, 15, 0);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(64'h0000_0001, 32, 20);
    check("t5 data_out",    64'(data_out),          64'h1);
    check("t5 good_count",  64'(good_count),        64'd1);
    check("t5 err_count",   64'(err_count),         64'd0);
    check("t5 err pulses",  64'(n_err_pulse - e0),  64'd0);

    // sclk and mosi activity with ss_n high
    e0 = n_err_pulse; o0 = n_ovr_pulse; v0 = n_valid_rise;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sclk = 1'b1;
      mosi = ~mosi;
      #2 mosi = ~mosi;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
      #3 mosi = ~mosi;
    end
    repeat (20) @(negedge clk);
    check("t6 good_count",  64'(good_count),         64'd1);
    check("t6 err_count",   64'(err_count),          64'd0);
    check("t6 no pulses",   64'(n_err_pulse - e0 + n_ovr_pulse - o0), 64'd0);
    check("t6 no delivery", 64'(n_valid_rise - v0),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
